// File: rtl/fft_frame_controller.sv
// Frame controller in front of the FFT core: buffers one input frame (zero-pad / truncate),
// streams it to the core, captures the results in place and replays them downstream.
module fft_frame_controller #(
    parameter int DATA_W     = 50,
    parameter int NUM_POINTS = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    output logic [DATA_W-1:0] core_in_data,
    output logic              core_in_last,
    input  logic              core_out_valid,
    input  logic [DATA_W-1:0] core_out_data,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);
    localparam int IDX_W = $clog2(NUM_POINTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

    typedef enum logic [2:0] {LOAD, PAD, DISCARD, SEND, COLLECT, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic               rd_done_q, rd_done_d;
    logic               res_done_q, res_done_d;
    logic               ov_q, ov_d;
    logic               ol_q, ol_d;
    logic               frame_err_q, frame_err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0]  od_q;
    logic [DATA_W-1:0]  mem_q [NUM_POINTS];

    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               load_rd;
    logic               streaming;
    logic               stream_rdy;
    logic               last_hs;

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        res_idx_d   = res_idx_q;
        rd_idx_d    = rd_idx_q;
        rd_done_d   = rd_done_q;
        res_done_d  = res_done_q;
        ov_d        = ov_q;
        ol_d        = ol_q;
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_idx_q;
        mem_wdata   = s_tdata;
        load_rd     = 1'b0;

        streaming  = (state_q == SEND) || (state_q == DRAIN);
        stream_rdy = (state_q == SEND) ? core_in_ready : m_tready;
        last_hs    = streaming && ov_q && ol_q && stream_rdy;

        // One-word output register refilled from the buffer whenever it empties or is consumed
        if (streaming) begin
            if ((!ov_q || stream_rdy) && !rd_done_q) begin
                load_rd = 1'b1;
                ov_d    = 1'b1;
                ol_d    = (rd_idx_q == LAST_IDX);
                if (rd_idx_q == LAST_IDX) begin
                    rd_done_d = 1'b1;
                    rd_idx_d  = '0;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end else if (ov_q && stream_rdy) begin
                ov_d = 1'b0;
                ol_d = 1'b0;
            end
            if (last_hs) begin
                rd_done_d = 1'b0;
            end
        end

        // Results may arrive while SEND is still running; they overwrite already-sent words
        if (((state_q == SEND) || (state_q == COLLECT)) && core_out_valid && !res_done_q) begin
            mem_we    = 1'b1;
            mem_waddr = res_idx_q;
            mem_wdata = core_out_data;
            if (res_idx_q == LAST_IDX) begin
                res_idx_d  = '0;
                res_done_d = 1'b1;
            end else begin
                res_idx_d = res_idx_q + 1'b1;
            end
        end

        case (state_q)
            LOAD: begin
                if (s_tvalid) begin
                    mem_we      = 1'b1;
                    mem_waddr   = wr_idx_q;
                    mem_wdata   = s_tdata;
                    frame_err_d = (wr_idx_q == LAST_IDX) && !s_tlast;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = s_tlast ? SEND : DISCARD;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                        if (s_tlast) state_d = PAD;
                    end
                end
            end
            PAD: begin
                mem_we    = 1'b1;
                mem_waddr = wr_idx_q;
                mem_wdata = '0;
                if (wr_idx_q == LAST_IDX) begin
                    wr_idx_d = '0;
                    state_d  = SEND;
                end else begin
                    wr_idx_d = wr_idx_q + 1'b1;
                end
            end
            DISCARD: begin
                if (s_tvalid && s_tlast) state_d = SEND;
            end
            SEND: begin
                if (last_hs) begin
                    if (res_done_d) begin
                        res_done_d = 1'b0;
                        state_d    = DRAIN;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (res_done_d) begin
                    res_done_d = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            res_idx_q   <= '0;
            rd_idx_q    <= '0;
            rd_done_q   <= 1'b0;
            res_done_q  <= 1'b0;
            ov_q        <= 1'b0;
            ol_q        <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            res_idx_q   <= res_idx_d;
            rd_idx_q    <= rd_idx_d;
            rd_done_q   <= rd_done_d;
            res_done_q  <= res_done_d;
            ov_q        <= ov_d;
            ol_q        <= ol_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Data storage carries no reset; only control state is cleared
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        if (load_rd) od_q <= mem_q[rd_idx_q];
    end

    assign s_tready      = (state_q == LOAD) || (state_q == DISCARD);
    assign core_in_valid = (state_q == SEND) && ov_q;
    assign core_in_last  = (state_q == SEND) && ol_q;
    assign core_in_data  = od_q;
    assign m_tvalid      = (state_q == DRAIN) && ov_q;
    assign m_tlast       = (state_q == DRAIN) && ol_q;
    assign m_tdata       = od_q;
    assign frame_err     = frame_err_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_controller.sv
// Directed bench for fft_frame_controller: an echoing core model and a collecting sink,
// advanced one clock per step from a single linear stimulus sequence.
module tb_fft_frame_controller;
    localparam int DW = 50;
    localparam int NP = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] s_tdata;
    logic          core_in_valid, core_in_ready, core_in_last;
    logic [DW-1:0] core_in_data;
    logic          core_out_valid;
    logic [DW-1:0] core_out_data;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    always #5 clk_i = ~clk_i;

    fft_frame_controller #(.DATA_W(DW), .NUM_POINTS(NP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_in_data(core_in_data), .core_in_last(core_in_last),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;

    beat_t         src_q[$];
    logic [DW-1:0] echo_q[$];
    logic [DW-1:0] crx_d[$];
    logic          crx_l[$];
    logic [DW-1:0] out_d[$];
    logic          out_l[$];
    logic [DW-1:0] exp_v [NP];

    int checks = 0;
    int errors = 0;
    int frames_out = 0;
    int beats_in = 0;
    bit rand_core = 1'b0;
    bit toggle_m = 1'b0;
    logic          prev_c_stall = 1'b0, prev_m_stall = 1'b0;
    logic [DW-1:0] prev_c_data = '0, prev_m_data = '0;
    logic          prev_c_last = 1'b0, prev_m_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive all partners, check hold behaviour, record handshakes, advance.
    task automatic step();
        beat_t b;
        logic  s_hs, c_hs, m_hs;
        b = '0;
        if (src_q.size() > 0) b = src_q[0];
        s_tvalid      = (src_q.size() > 0);
        s_tdata       = b.data;
        s_tlast       = b.last;
        core_in_ready = rand_core ? 1'($urandom_range(0, 1)) : 1'b1;
        m_tready      = toggle_m ? ~m_tready : 1'b1;
        if (echo_q.size() > 0) begin
            core_out_valid = 1'b1;
            core_out_data  = echo_q.pop_front();
        end else begin
            core_out_valid = 1'b0;
            core_out_data  = '0;
        end
        if (prev_c_stall) begin
            chk("core_hold_valid", 64'(core_in_valid), 64'(1));
            chk("core_hold_data", 64'(core_in_data), 64'(prev_c_data));
            chk("core_hold_last", 64'(core_in_last), 64'(prev_c_last));
        end
        if (prev_m_stall) begin
            chk("m_hold_valid", 64'(m_tvalid), 64'(1));
            chk("m_hold_data", 64'(m_tdata), 64'(prev_m_data));
            chk("m_hold_last", 64'(m_tlast), 64'(prev_m_last));
        end
        s_hs = s_tvalid && s_tready;
        c_hs = core_in_valid && core_in_ready;
        m_hs = m_tvalid && m_tready;
        if (s_hs) begin
            void'(src_q.pop_front());
            beats_in++;
        end
        if (c_hs) begin
            crx_d.push_back(core_in_data);
            crx_l.push_back(core_in_last);
            echo_q.push_back(core_in_data);
        end
        if (m_hs) begin
            out_d.push_back(m_tdata);
            out_l.push_back(m_tlast);
            if (m_tlast) begin
                frames_out++;
                chk("s_tready_at_m_tlast", 64'(s_tready), 64'(0));
            end
        end
        prev_c_stall = core_in_valid && !core_in_ready;
        prev_c_data  = core_in_data;
        prev_c_last  = core_in_last;
        prev_m_stall = m_tvalid && !m_tready;
        prev_m_data  = m_tdata;
        prev_m_last  = m_tlast;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_frame(input logic [DW-1:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + DW'(i);
            b.last = (i == n - 1);
            src_q.push_back(b);
        end
    endtask

    task automatic run_until(input int n_frames, input string tag);
        int cyc;
        cyc = 0;
        while (frames_out < n_frames && cyc < 400) begin
            step();
            cyc++;
        end
        chk(tag, 64'(frames_out), 64'(n_frames));
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_core_n"}, 64'(crx_d.size()), 64'(NP));
        chk({tag, "_out_n"}, 64'(out_d.size()), 64'(NP));
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("%s_core_d%0d", tag, i), 64'(crx_d[i]), 64'(exp_v[i]));
            chk($sformatf("%s_core_l%0d", tag, i), 64'(crx_l[i]), 64'(i == NP - 1));
            chk($sformatf("%s_out_d%0d", tag, i), 64'(out_d[i]), 64'(exp_v[i]));
            chk($sformatf("%s_out_l%0d", tag, i), 64'(out_l[i]), 64'(i == NP - 1));
        end
        crx_d.delete(); crx_l.delete(); out_d.delete(); out_l.delete();
    endtask

    task automatic clear_bench();
        src_q.delete(); echo_q.delete();
        crx_d.delete(); crx_l.delete(); out_d.delete(); out_l.delete();
        frames_out = 0; beats_in = 0;
        prev_c_stall = 1'b0; prev_m_stall = 1'b0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        core_out_valid = 1'b0; core_out_data = '0;
        core_in_ready = 1'b1; m_tready = 1'b1;
    endtask

    initial begin
        int n;
        rst_ni = 1'b0;
        clear_bench();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_s_tready", 64'(s_tready), 64'(1));
        chk("rst_core_in_valid", 64'(core_in_valid), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_frame_err", 64'(frame_err), 64'(0));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        rst_ni = 1'b1;

        // T1: full frame 1..8
        push_frame(DW'(1), 8);
        n = 0;
        while (src_q.size() > 0 && n < 50) begin step(); n++; end
        chk("t1_accept_cycles", 64'(n), 64'(8));
        run_until(1, "t1_done");
        for (int i = 0; i < NP; i++) exp_v[i] = DW'(i + 1);
        check_frame("t1");
        chk("t1_frame_cnt", 64'(frame_cnt), 64'(1));
        chk("t1_frame_err", 64'(frame_err), 64'(0));
        chk("t1_s_tready_after", 64'(s_tready), 64'(1));

        // T2: short frame gets zero padded
        push_frame(DW'(5), 3);
        run_until(2, "t2_done");
        for (int i = 0; i < NP; i++) exp_v[i] = (i < 3) ? DW'(i + 5) : '0;
        check_frame("t2");
        chk("t2_frame_cnt", 64'(frame_cnt), 64'(2));

        // T3: over-long frame truncated to its first 8 samples
        beats_in = 0;
        push_frame(DW'(1), 11);
        n = 0;
        while (src_q.size() > 0 && n < 50) begin step(); n++; end
        chk("t3_accept_cycles", 64'(n), 64'(11));
        chk("t3_beats_in", 64'(beats_in), 64'(11));
        run_until(3, "t3_done");
        for (int i = 0; i < NP; i++) exp_v[i] = DW'(i + 1);
        check_frame("t3");
        chk("t3_frame_err", 64'(frame_err), 64'(1));
        chk("t3_frame_cnt", 64'(frame_cnt), 64'(3));

        // T4: stalls on both sides; first beat of this frame clears frame_err
        push_frame(50'h2_AAAA_5555_0000, 8);
        rand_core = 1'b1;
        toggle_m  = 1'b1;
        step();
        chk("t4_frame_err_cleared", 64'(frame_err), 64'(0));
        run_until(4, "t4_done");
        for (int i = 0; i < NP; i++) exp_v[i] = 50'h2_AAAA_5555_0000 + DW'(i);
        check_frame("t4");
        chk("t4_frame_cnt", 64'(frame_cnt), 64'(4));
        rand_core = 1'b0;
        toggle_m  = 1'b0;

        // T5: reset in the middle of DRAIN
        push_frame(DW'('h10), 8);
        n = 0;
        while (out_d.size() < 3 && n < 100) begin step(); n++; end
        chk("t5_three_out", 64'(out_d.size()), 64'(3));
        chk("t5_pre_m_tvalid", 64'(m_tvalid), 64'(1));
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("t5_rst_frame_cnt", 64'(frame_cnt), 64'(0));
        clear_bench();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("t5_rel_s_tready", 64'(s_tready), 64'(1));
        chk("t5_rel_m_tvalid", 64'(m_tvalid), 64'(0));
        push_frame(DW'('h20), 8);
        run_until(1, "t5_done");
        for (int i = 0; i < NP; i++) exp_v[i] = DW'('h20 + i);
        check_frame("t5");
        chk("t5_frame_cnt", 64'(frame_cnt), 64'(1));

        // T6: three frames back to back with s_tvalid held high
        rst_ni = 1'b0;
        clear_bench();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("t6_frame_cnt_rst", 64'(frame_cnt), 64'(0));
        push_frame(DW'('h100), 8);
        push_frame(DW'('h200), 8);
        push_frame(DW'('h300), 8);
        run_until(1, "t6_f1");
        chk("t6_s_tready_f1", 64'(s_tready), 64'(1));
        run_until(2, "t6_f2");
        chk("t6_s_tready_f2", 64'(s_tready), 64'(1));
        run_until(3, "t6_f3");
        chk("t6_s_tready_f3", 64'(s_tready), 64'(1));
        chk("t6_frame_cnt", 64'(frame_cnt), 64'(3));
        chk("t6_beats_in", 64'(beats_in), 64'(24));
        chk("t6_src_left", 64'(src_q.size()), 64'(0));
        chk("t6_out_n", 64'(out_d.size()), 64'(24));
        chk("t6_core_n", 64'(crx_d.size()), 64'(24));
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("t6_out_d%0d", i), 64'(out_d[i]), 64'(((i / 8) + 1) * 256 + (i % 8)));
            chk($sformatf("t6_out_l%0d", i), 64'(out_l[i]), 64'((i % 8) == 7));
            chk($sformatf("t6_core_d%0d", i), 64'(crx_d[i]), 64'(((i / 8) + 1) * 256 + (i % 8)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
